// File: rtl/alu_register_type_muldiv_if.sv
// ============================================================================
// alu_register_type_muldiv_if : operand/result handshake bundle for the R-type execute unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_register_type_muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      subfunction_3;
  logic [6:0]      subfunction_7;
  logic [XLEN-1:0] input_register1_value;
  logic [XLEN-1:0] input_register2_value;
  logic            out_valid;
  logic            out_ready;
  logic            error;
  logic [XLEN-1:0] result_to_write_rd;

  modport master (
    output in_valid, subfunction_3, subfunction_7,
    output input_register1_value, input_register2_value, out_ready,
    input  in_ready, out_valid, error, result_to_write_rd
  );

  modport slave (
    input  in_valid, subfunction_3, subfunction_7,
    input  input_register1_value, input_register2_value, out_ready,
    output in_ready, out_valid, error, result_to_write_rd
  );
endinterface

`default_nettype wire

// File: rtl/alu_register_type_muldiv.sv
// ============================================================================
// alu_register_type_muldiv : RV R-type execute unit, single-cycle base ops plus iterative M ops
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_register_type_muldiv #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  alu_register_type_muldiv_if.slave    bus
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] rs1, rs2, base_res, sra_res, m_result;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [SW-1:0]   shamt;
  logic            accept, is_base, is_alt, is_m, legal, m_last;

  assign rs1    = bus.input_register1_value;
  assign rs2    = bus.input_register2_value;
  assign f3     = bus.subfunction_3;
  assign f7     = bus.subfunction_7;
  assign shamt  = rs2[SW-1:0];
  assign accept = (state_q == IDLE) && bus.in_valid;

  assign is_base = (f7 == 7'b0000000);
  assign is_alt  = (f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101));
  assign is_m    = ENABLE_M && (f7 == 7'b0000001);
  assign legal   = is_base || is_alt;

  // Kept separate so the arithmetic shift is not demoted by an unsigned ternary partner
  assign sra_res = $signed(rs1) >>> shamt;

  always_comb begin
    base_res = '0;
    case (f3)
      3'b000:  base_res = is_alt ? (rs1 - rs2) : (rs1 + rs2);
      3'b001:  base_res = rs1 << shamt;
      3'b010:  base_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      3'b011:  base_res = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      3'b100:  base_res = rs1 ^ rs2;
      3'b101:  base_res = is_alt ? sra_res : (rs1 >> shamt);
      3'b110:  base_res = rs1 | rs2;
      3'b111:  base_res = rs1 & rs2;
      default: base_res = '0;
    endcase
  end

  generate
    if (ENABLE_M) begin : g_muldiv
      logic [2*XLEN-1:0] prod_q, step, fixed;
      logic [XLEN-1:0]   b_q, a_mag, b_mag, quot, rem;
      logic [XLEN:0]     mul_sum, div_shift, div_diff;
      logic [2:0]        op_q;
      logic              neg_q, dz_q, a_sgn, b_sgn, neg_d;
      logic [SW-1:0]     cnt_q;

      // Divides are signed when funct3[0]=0; MULH takes both signs, MULHSU only rs1
      always_comb begin
        a_sgn = f3[2] ? (!f3[0] && rs1[XLEN-1])
                      : (((f3 == 3'b001) || (f3 == 3'b010)) && rs1[XLEN-1]);
        b_sgn = f3[2] ? (!f3[0] && rs2[XLEN-1])
                      : ((f3 == 3'b001) && rs2[XLEN-1]);
        a_mag = a_sgn ? -rs1 : rs1;
        b_mag = b_sgn ? -rs2 : rs2;
        neg_d = (f3[2] && f3[1]) ? a_sgn : (a_sgn ^ b_sgn);
      end

      assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
      assign div_shift = prod_q[2*XLEN-1:XLEN-1];
      assign div_diff  = div_shift - {1'b0, b_q};

      always_comb begin
        if (op_q[2]) begin
          step = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0],  prod_q[XLEN-2:0], 1'b1};
        end else begin
          step = {mul_sum, prod_q[XLEN-1:1]};
        end
      end

      assign fixed = neg_q ? -step : step;
      assign quot  = step[XLEN-1:0];
      assign rem   = step[2*XLEN-1:XLEN];

      always_comb begin
        m_result = '0;
        case (op_q)
          3'b000:                m_result = fixed[XLEN-1:0];
          3'b001, 3'b010, 3'b011: m_result = fixed[2*XLEN-1:XLEN];
          3'b100, 3'b101:        m_result = dz_q ? '1 : (neg_q ? -quot : quot);
          default:               m_result = neg_q ? -rem : rem;
        endcase
      end

      assign m_last = (state_q == BUSY) && (cnt_q == SW'(XLEN-1));

      // Low half holds the multiplier or the dividend; it is shifted out as bits are consumed
      always_ff @(posedge clk) begin
        if (reset) begin
          prod_q <= '0;
          b_q    <= '0;
          op_q   <= '0;
          neg_q  <= 1'b0;
          dz_q   <= 1'b0;
          cnt_q  <= '0;
        end else if (accept && is_m) begin
          prod_q <= {{XLEN{1'b0}}, (f3[2] ? a_mag : b_mag)};
          b_q    <= f3[2] ? b_mag : a_mag;
          op_q   <= f3;
          neg_q  <= neg_d;
          dz_q   <= (rs2 == '0);
          cnt_q  <= '0;
        end else if (state_q == BUSY) begin
          prod_q <= step;
          cnt_q  <= cnt_q + SW'(1);
        end
      end
    end else begin : g_no_muldiv
      assign m_result = '0;
      assign m_last   = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_m) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            err_d   = !legal;
            res_d   = legal ? base_res : '0;
          end
        end
      end
      BUSY: begin
        if (m_last) begin
          state_d = DONE;
          res_d   = m_result;
          err_d   = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready           = (state_q == IDLE);
  assign bus.out_valid          = (state_q == DONE);
  assign bus.error              = err_q;
  assign bus.result_to_write_rd = res_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_register_type_muldiv.sv
// ============================================================================
// tb_alu_register_type_muldiv : directed vectors with a queue scoreboard and decoupled monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_register_type_muldiv;

  localparam int XLEN = 32;
  localparam logic [6:0] F7B = 7'b0000000;
  localparam logic [6:0] F7A = 7'b0100000;
  localparam logic [6:0] F7M = 7'b0000001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_register_type_muldiv_if #(.XLEN(XLEN)) bus ();
  alu_register_type_muldiv_if #(.XLEN(XLEN)) bus_nm ();

  alu_register_type_muldiv #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_register_type_muldiv #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nm (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nm)
  );

  typedef struct {
    logic [XLEN-1:0] res;
    logic            err;
    int              lat;
    int              acc;
    string           name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   first_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: compares every presented cycle so a stalled result must stay stable
  always @(negedge clk) begin
    if (reset) begin
      first_seen = 1'b0;
    end else if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        if (!first_seen) begin
          first_seen = 1'b1;
          chk({sbq[0].name, "_latency"}, 32'(cyc - sbq[0].acc + 1), 32'(sbq[0].lat));
        end
        chk({sbq[0].name, "_result"}, bus.result_to_write_rd, sbq[0].res);
        chk({sbq[0].name, "_error"}, 32'(bus.error), 32'(sbq[0].err));
        chk({sbq[0].name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        if (bus.out_ready) begin
          void'(sbq.pop_front());
          first_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [6:0] f7, input logic [2:0] f3,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] er, input logic ee,
                       input string nm, input bit track = 1'b1);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    bus.in_valid              = 1'b1;
    bus.subfunction_7         = f7;
    bus.subfunction_3         = f3;
    bus.input_register1_value = a;
    bus.input_register2_value = b;
    while (!bus.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      chk({nm, "_accept_timeout"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (track) begin
      e.res  = er;
      e.err  = ee;
      e.lat  = ((f7 == F7M) && !ee) ? XLEN + 1 : 1;
      e.acc  = cyc;
      e.name = nm;
      sbq.push_back(e);
    end
    // Scramble inputs after acceptance; the captured operation must be unaffected
    bus.in_valid              = 1'b0;
    bus.subfunction_7         = 7'h55;
    bus.subfunction_3         = 3'h6;
    bus.input_register1_value = 32'hA5A5_5A5A;
    bus.input_register2_value = 32'h1234_5678;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sbq.size() != 0 || !bus.in_ready) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  task automatic nm_check(input logic [6:0] f7, input logic [2:0] f3,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] er, input logic ee, input string nm);
    @(negedge clk);
    bus_nm.in_valid              = 1'b1;
    bus_nm.subfunction_7         = f7;
    bus_nm.subfunction_3         = f3;
    bus_nm.input_register1_value = a;
    bus_nm.input_register2_value = b;
    @(negedge clk);
    bus_nm.in_valid = 1'b0;
    chk({nm, "_valid"}, 32'(bus_nm.out_valid), 32'd1);
    chk({nm, "_result"}, bus_nm.result_to_write_rd, er);
    chk({nm, "_error"}, 32'(bus_nm.error), 32'(ee));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset                     = 1'b1;
    bus.in_valid              = 1'b0;
    bus.out_ready             = 1'b1;
    bus.subfunction_3         = '0;
    bus.subfunction_7         = '0;
    bus.input_register1_value = '0;
    bus.input_register2_value = '0;
    bus_nm.in_valid              = 1'b0;
    bus_nm.out_ready             = 1'b1;
    bus_nm.subfunction_3         = '0;
    bus_nm.subfunction_7         = '0;
    bus_nm.input_register1_value = '0;
    bus_nm.input_register2_value = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_error", 32'(bus.error), 32'd0);
    chk("reset_result", bus.result_to_write_rd, 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

    issue(F7B, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0, "ADD");
    issue(F7A, 3'b000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, "SUB");
    issue(F7A, 3'b101, 32'hFFFF_FFF0, 32'h22, 32'hFFFF_FFFC, 1'b0, "SRA");
    issue(F7B, 3'b101, 32'hFFFF_FFF0, 32'h22, 32'h3FFF_FFFC, 1'b0, "SRL");
    issue(F7B, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "SLT");
    issue(F7B, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "SLTU");
    issue(F7B, 3'b001, 32'h0000_00F1, 32'h24, 32'h0000_0F10, 1'b0, "SLL");
    issue(F7B, 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, "XOR");
    issue(F7B, 3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, "OR");
    issue(F7B, 3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, "AND");
    issue(7'b0010000, 3'b000, 32'd5, 32'd7, 32'd0, 1'b1, "ERR_F7");
    issue(F7A, 3'b111, 32'd5, 32'd7, 32'd0, 1'b1, "ERR_ALT_AND");
    issue(F7A, 3'b001, 32'd5, 32'd7, 32'd0, 1'b1, "ERR_ALT_SLL");

    issue(F7M, 3'b000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, "MUL");
    issue(F7M, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "MULH_MIN");
    issue(F7M, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, "MULH_M1");
    issue(F7M, 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, "MULHSU");
    issue(F7M, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "MULHU");
    issue(F7M, 3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, "DIV_BY0");
    issue(F7M, 3'b110, 32'd7, 32'd0, 32'd7, 1'b0, "REM_BY0");
    issue(F7M, 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0, "DIV_NEG_BY0");
    issue(F7M, 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0, "REM_NEG_BY0");
    issue(F7M, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "DIV_OVF");
    issue(F7M, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, "REM_OVF");
    issue(F7M, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "DIV_M7_2");
    issue(F7M, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "REM_M7_2");
    issue(F7M, 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "DIV_7_M2");
    issue(F7M, 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, "REM_7_M2");
    issue(F7M, 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0, "DIVU");
    issue(F7M, 3'b111, 32'hFFFF_FFF9, 32'd2, 32'd1, 1'b0, "REMU");
    issue(F7M, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, "DIVU_100_7");
    issue(F7M, 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, "REMU_100_7");
    drain();

    // Writeback stall with a second operation already waiting upstream
    bus.out_ready = 1'b0;
    issue(F7B, 3'b000, 32'h1000_0000, 32'h0000_0001, 32'h1000_0001, 1'b0, "ADD_STALL");
    fork
      begin
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join_none
    issue(F7B, 3'b100, 32'h0000_FFFF, 32'h0F0F_0F0F, 32'h0F0F_F0F0, 1'b0, "XOR_AFTER_STALL");
    drain();

    // Reset in the middle of a multiply: nothing may be presented afterwards
    issue(F7M, 3'b000, 32'd9, 32'd9, 32'd81, 1'b0, "MUL_ABORT", 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_result", bus.result_to_write_rd, 32'd0);
    repeat (40) @(negedge clk);
    issue(F7B, 3'b000, 32'd1, 32'd2, 32'd3, 1'b0, "ADD_AFTER_ABORT");
    drain();

    nm_check(F7M, 3'b000, 32'd3, 32'd4, 32'd0, 1'b1, "NOM_MUL");
    nm_check(F7M, 3'b100, 32'd8, 32'd2, 32'd0, 1'b1, "NOM_DIV");
    nm_check(F7B, 3'b000, 32'd2, 32'd3, 32'd5, 1'b0, "NOM_ADD");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
